ysyx_23060180_mem_arbiter: RTL

//  Shares the core's single memory port between instruction fetch (IFU) and load/store (LSU).

---
 rtl/ysyx_23060180_mem_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060180_mem_arbiter.sv
// rtl/ysyx_23060180_mem_arbiter.sv - round-robin arbiter sharing one memory port between IFU and LSU
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   ifu_req/addr -> ifu_gnt, ifu_rvalid, ifu_rdata
//                                 instruction fetch requester (read only)
//   lsu_req/addr/wen/wdata/wmask -> lsu_gnt, lsu_rvalid, lsu_rdata
//                                 load/store requester
//   mem_req/addr/wen/wdata/wmask, mem_gnt, mem_rvalid, mem_rdata
//                                 single outstanding-transaction memory port
//   arb_err                       pulses with the aborted owner's rvalid on timeout
//
// Optional feature: define ARB_TIMEOUT_EN to abort a transaction that has spent
// TIMEOUT_CYCLES cycles in REQ+WAIT; the owner then gets rdata 32'hDEADBEEF and
// arb_err. Without the macro the arbiter waits indefinitely and arb_err stays 0.

module ysyx_23060180_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    output logic        ifu_gnt,
    output logic        ifu_rvalid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_gnt,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        arb_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    state_t state_q, state_d;
    logic   owner_q;
    logic   last_owner_q;
    logic   pick_lsu;
    logic   any_req;
    logic   complete;
    logic   abort;

    assign any_req = ifu_req | lsu_req;

    // On a tie the requester that was not served last wins.
    always_comb begin
        pick_lsu = 1'b0;
        if (ifu_req && lsu_req) begin
            pick_lsu = (last_owner_q == OWNER_IFU);
        end else begin
            pick_lsu = lsu_req;
        end
    end

    // A response in REQ only counts when it arrives together with the grant.
    assign complete = ((state_q == S_REQ) && mem_gnt && mem_rvalid) ||
                      ((state_q == S_WAIT) && mem_rvalid);

`ifdef ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES) + 1 > 9) ? $clog2(TIMEOUT_CYCLES) + 1 : 9;

    logic [CW-1:0] cnt_q;

    // Held at zero in IDLE so it starts from zero on the first REQ cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == S_IDLE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign abort = (state_q != S_IDLE) && !complete &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;

    assign unused_timeout = |TIMEOUT_CYCLES;
    assign abort          = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        ifu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                mem_req = 1'b1;
                ifu_gnt = mem_gnt && (owner_q == OWNER_IFU);
                lsu_gnt = mem_gnt && (owner_q == OWNER_LSU);
                if (complete || abort) begin
                    state_d = S_IDLE;
                end else if (mem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (complete || abort) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWNER_IFU;
            last_owner_q <= OWNER_IFU;
            mem_addr     <= 32'h0;
            mem_wen      <= 1'b0;
            mem_wdata    <= 32'h0;
            mem_wmask    <= 4'h0;
            ifu_rvalid   <= 1'b0;
            ifu_rdata    <= 32'h0;
            lsu_rvalid   <= 1'b0;
            lsu_rdata    <= 32'h0;
            arb_err      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ifu_rvalid <= 1'b0;
            lsu_rvalid <= 1'b0;
            arb_err    <= 1'b0;

            if ((state_q == S_IDLE) && any_req) begin
                owner_q   <= pick_lsu;
                mem_addr  <= pick_lsu ? lsu_addr : ifu_addr;
                mem_wen   <= pick_lsu & lsu_wen;
                mem_wdata <= pick_lsu ? lsu_wdata : 32'h0;
                mem_wmask <= pick_lsu ? lsu_wmask : 4'h0;
            end

            // Response routing; the non-owner's rdata keeps its old value.
            if (complete || abort) begin
                last_owner_q <= owner_q;
                arb_err      <= abort;
                if (owner_q == OWNER_LSU) begin
                    lsu_rvalid <= 1'b1;
                    lsu_rdata  <= abort ? 32'hDEADBEEF : mem_rdata;
                end else begin
                    ifu_rvalid <= 1'b1;
                    ifu_rdata  <= abort ? 32'hDEADBEEF : mem_rdata;
                end
            end
        end
    end

endmodule
